// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB4 signal bundle for the bridge
interface apb_master_bridge_if #(
  parameter int PADDR_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [PADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;
  logic [PADDR_WIDTH-1:0]  paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata, pstrb
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB4 SETUP/ACCESS requester with wait-state timeout
module apb_master_bridge #(
  parameter int PADDR_WIDTH    = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic pclk,
  input logic presetn,
  apb_master_bridge_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [PADDR_WIDTH-1:0] r_paddr;
  logic                   r_psel;
  logic                   r_penable;
  logic                   r_pwrite;
  logic [DATA_WIDTH-1:0]  r_pwdata;
  logic [SW-1:0]          r_pstrb;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_rsp_timeout;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_timeout;
  assign w_cnt_nxt = r_cnt + 1'b1;
  // TIMEOUT_CYCLES==0 leaves the counter free-running but never aborts
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == TO_LIM);
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_paddr   <= bus.cmd_addr;
          r_pwrite  <= bus.cmd_write;
          r_pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
          r_pstrb   <= bus.cmd_write ? bus.cmd_strb : '0;
          r_psel    <= 1'b1;
          r_penable <= 1'b0;
          r_state   <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: if (bus.pready) begin
          r_psel        <= 1'b0;
          r_penable     <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_rsp_err     <= bus.pslverr;
          r_rsp_timeout <= 1'b0;
          r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
          r_state       <= RESP;
        end else begin
          r_cnt <= w_cnt_nxt;
          if (w_timeout) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= RESP;
          end
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready   = (r_state == IDLE);
  assign bus.paddr       = r_paddr;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwdata      = r_pwdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vector bench with a byte-strobed SRAM completer model
module tb_apb_master_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  apb_master_bridge_if #(.PADDR_WIDTH(16), .DATA_WIDTH(32)) bus();
  apb_master_bridge #(.PADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk(clk), .presetn(rst_n), .bus(bus.master)
  );
  logic [31:0] mem [16];
  int          waits = 0;
  int          acc_cnt = 0;
  logic        stuck = 1'b0;
  logic        err = 1'b0;
  logic        ovr = 1'b0;
  logic [31:0] ovr_data = '0;
  int          checks = 0;
  int          errors = 0;
  assign bus.pready  = !stuck && (acc_cnt >= waits);
  assign bus.prdata  = ovr ? ovr_data : mem[bus.paddr[5:2]];
  assign bus.pslverr = err;
  always @(posedge clk) begin
    acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      for (int b = 0; b < 4; b++)
        if (bus.pstrb[b]) mem[bus.paddr[5:2]][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
  end
  typedef struct {
    logic wr; logic [15:0] addr; logic [31:0] wdata; logic [3:0] strb;
    int waits; logic stuck; logic err; logic ovr; logic [31:0] ovr_data; int hold;
    logic [31:0] exp_rdata; logic exp_err; logic exp_to; int exp_lat;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int lat = 0, ps = 0, pe = 0, bad = 0, moved = 0;
    logic [34:0] snap;
    @(negedge clk);
    waits = v.waits; stuck = v.stuck; err = v.err; ovr = v.ovr; ovr_data = v.ovr_data;
    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr;
    bus.cmd_wdata = v.wdata; bus.cmd_strb = v.strb; bus.rsp_ready = 1'b0;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    while (lat < 50) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      lat++;
      if (bus.rsp_valid) break;
      ps += int'(bus.psel);
      pe += int'(bus.penable);
      if (bus.psel && (bus.paddr !== v.addr || bus.pwrite !== v.wr ||
          bus.pstrb !== (v.wr ? v.strb : 4'h0) || bus.pwdata !== (v.wr ? v.wdata : 32'h0))) bad++;
    end
    chk("latency", lat, v.exp_lat);
    chk("psel_cycles", ps, v.exp_lat - 1);
    chk("penable_cycles", pe, v.exp_lat - 2);
    chk("apb_bus_stable", bad, 0);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, v.exp_to});
    chk("psel_off_in_resp", {30'd0, bus.psel, bus.penable}, 32'd0);
    snap = {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== snap || bus.cmd_ready) moved++;
    end
    if (v.hold > 0) chk("rsp_hold_stable", moved, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask
  vec_t vecs [11];
  initial begin
    int stray = 0;
    //          wr   addr      wdata         strb  wt stk err ovr ovr_data       hold rdata         e  to lat
    vecs[0]  = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b1, 16'h0004, 32'h00001234, 4'h3, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, 16'h0004, 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'hDEAD1234, 1'b0, 1'b0, 3};
    vecs[4]  = '{1'b1, 16'h0008, 32'hCAFEF00D, 4'hF, 3, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 6};
    vecs[5]  = '{1'b0, 16'h0008, 32'h0, 4'h0, 3, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 6};
    vecs[6]  = '{1'b0, 16'h000C, 32'h0, 4'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b1, 6};
    vecs[7]  = '{1'b1, 16'h0010, 32'h11223344, 4'hF, 0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b1, 6};
    vecs[8]  = '{1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, 16'h0014, 32'h0, 4'h0, 0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 5, 32'h55AA55AA, 1'b1, 1'b0, 3};
    vecs[10] = '{1'b1, 16'h0018, 32'hA5A5A5A5, 4'hF, 1, 1'b0, 1'b1, 1'b0, 32'h0, 2, 32'h0, 1'b1, 1'b0, 4};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_apb", {bus.psel, bus.penable, bus.pwrite, bus.pstrb, bus.paddr}, 32'd0);
    chk("reset_pwdata", bus.pwdata, 32'd0);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) run(vecs[i]);
    @(negedge clk);
    err = 1'b0; ovr = 1'b0; stuck = 1'b1; waits = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h001C;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_penable", {30'd0, bus.psel, bus.penable}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_apb", {30'd0, bus.psel, bus.penable}, 32'd0);
    chk("async_reset_rsp_cmd", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1; stuck = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stray += int'(bus.rsp_valid) + int'(bus.psel);
    end
    chk("no_stray_after_reset", stray, 0);
    run(vecs[3]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
